mem_responder: RTL

Responder end of the core's instruction and data memory interfaces: a single-ported, word-organised on-chip memory that serves `inst_*` and `data_*` requests from the pipelined RV32I datapath with a programmable fixed latency. The block sits directly below the datapath in simulation and FPGA builds, in place of caches and physical memory. It arbitrates between the two ports, applies byte enables on stores, and returns read data with a one-cycle `resp` pulse.

---
 rtl/mem_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-ported word memory that serves the instruction and
// data ports of the RV32I datapath. Each access takes a fixed LATENCY, and
// both ports share the one array through a round-robin arbiter.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accept one request (round-robin when both ports are pending)
// WAIT  | count down LATENCY-1 cycles (skipped when LATENCY == 1)
// RESP  | serving port's resp is high; always returns to IDLE
module mem_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read,
  input  logic [31:0] inst_addr,
  output logic        inst_resp,
  output logic [31:0] inst_rdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_mbe,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_resp,
  output logic [31:0] data_rdata,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // WAIT is entered holding LATENCY-2 and leaves for RESP once it reads zero
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                state;
  logic [3:0]            cnt;
  logic                  rr_data;   // 1: data port wins the next contention
  logic                  port_q;    // 1: data port, 0: instruction port
  logic                  wr_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            mbe_q;

  logic [31:0] mem [2**DEPTH_LOG2];

  logic                  inst_pend;
  logic                  data_pend;
  logic                  sel_data;
  logic                  accept;
  logic                  a_data;
  logic                  a_wr;
  logic [DEPTH_LOG2-1:0] a_idx;
  logic [31:0]           a_wdata;
  logic [3:0]            a_mbe;
  logic                  go_resp;
  logic                  mem_we;

  // Only the word-index bits address the array; the rest alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[31:DEPTH_LOG2+2], inst_addr[1:0],
                              data_addr[31:DEPTH_LOG2+2], data_addr[1:0]};

  // Arbitration and selection of the access that completes on the next edge.
  // With LATENCY == 1 it completes straight from IDLE using the live inputs.
  always_comb begin
    inst_pend = inst_read;
    data_pend = data_read | data_write;
    sel_data  = data_pend & (~inst_pend | rr_data);
    accept    = (state == IDLE) & (inst_pend | data_pend);
    a_data    = port_q;
    a_wr      = wr_q;
    a_idx     = idx_q;
    a_wdata   = wdata_q;
    a_mbe     = mbe_q;
    if (state == IDLE) begin
      a_data  = sel_data;
      a_wr    = sel_data & data_write;
      a_idx   = sel_data ? data_addr[DEPTH_LOG2+1:2] : inst_addr[DEPTH_LOG2+1:2];
      a_wdata = data_wdata;
      a_mbe   = data_mbe;
    end
    go_resp = ((state == IDLE) & accept & (LATENCY == 1)) |
              ((state == WAIT) & (cnt == 4'd0));
    // A write still in flight when reset is asserted never reaches the array.
    mem_we  = rst & go_resp & a_data & a_wr;
  end

  // Byte-lane write into the array on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (a_mbe[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  // Control FSM with latched request, round-robin pointer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      rr_data    <= 1'b1;
      port_q     <= 1'b0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      mbe_q      <= 4'd0;
      inst_resp  <= 1'b0;
      data_resp  <= 1'b0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
      proto_err  <= 1'b0;
    end else begin
      inst_resp <= 1'b0;
      data_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            port_q  <= sel_data;
            wr_q    <= sel_data & data_write;
            idx_q   <= a_idx;
            wdata_q <= data_wdata;
            mbe_q   <= data_mbe;
            rr_data <= ~sel_data;
            if (sel_data & data_read & data_write) proto_err <= 1'b1;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        if (a_data) begin
          data_resp <= 1'b1;
          if (!a_wr) data_rdata <= mem[a_idx];
        end else begin
          inst_resp  <= 1'b1;
          inst_rdata <= mem[a_idx];
        end
      end
    end
  end

endmodule
